// File: rtl/fib_bcd_display.sv
// ============================================================================
// Module   : fib_bcd_display
// Purpose  : Captures 16-bit values from the Fibonacci generator and converts
//            each one to five BCD digits with a 16-step shift-add-3 engine.
//            The last result drives a time-multiplexed 5-digit 7-segment
//            display with leading-zero blanking.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   d_in       in  16   unsigned binary value to convert
//   d_valid    in   1   d_in qualifier, level-sampled each edge
//   busy       out  1   conversion in progress
//   bcd        out 20   last completed conversion, bcd[3:0] = ones
//   bcd_valid  out  1   one-cycle pulse when bcd updates
//   drop       out  1   sticky: a value arrived while busy
//   seg        out  7   active-low segments {g,f,e,d,c,b,a}
//   an         out  5   active-low one-hot digit enable, an[0] = ones
// ============================================================================
`default_nettype none

module fib_bcd_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        d_valid,
    output logic        busy,
    output logic [19:0] bcd,
    output logic        bcd_valid,
    output logic        drop,
    output logic [6:0]  seg,
    output logic [4:0]  an
);

    localparam int        CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [15:0] shreg_q,     shreg_d;
    logic [19:0] scratch_q,   scratch_d;
    logic [3:0]  step_q,      step_d;
    logic        busy_q,      busy_d;
    logic [19:0] bcd_q,       bcd_d;
    logic        bcd_valid_q, bcd_valid_d;
    logic        drop_q,      drop_d;

    // Display scan state
    logic [CNT_W-1:0] scan_q, scan_d;
    logic [2:0]       idx_q,  idx_d;

    logic [19:0] w_adj;
    logic [35:0] w_cat;
    logic [35:0] w_shifted;

    // Add-3 correction: any nibble >= 5 would become >= 10 after doubling.
    always_comb begin
        w_adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The top bit of the scratch falls off; it is always zero for 16-bit input.
    assign w_cat     = {w_adj, shreg_q};
    assign w_shifted = w_cat << 1;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        step_d      = step_q;
        busy_d      = busy_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        drop_d      = drop_q;

        case (state_q)
            S_IDLE: begin
                if (d_valid) begin
                    shreg_d   = d_in;
                    scratch_d = 20'h00000;
                    step_d    = 4'd0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A value offered during a conversion is lost, including on
                // the final step; the conversion itself carries on.
                if (d_valid) begin
                    drop_d = 1'b1;
                end
                scratch_d = w_shifted[35:16];
                shreg_d   = w_shifted[15:0];
                step_d    = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    bcd_d       = w_shifted[35:16];
                    bcd_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (scan_q == CNT_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end else begin
            scan_d = scan_q + CNT_W'(1);
            idx_d  = idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= 16'h0000;
            scratch_q   <= 20'h00000;
            step_q      <= 4'd0;
            busy_q      <= 1'b0;
            bcd_q       <= 20'h00000;
            bcd_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            scan_q      <= '0;
            idx_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
            drop_q      <= drop_d;
            scan_q      <= scan_d;
            idx_q       <= idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Display decode
    // ------------------------------------------------------------------------
    logic [19:0] w_hi;
    logic [3:0]  w_nib;
    logic        w_blank;

    // Shifting bcd down by the digit index leaves the current digit in the
    // low nibble and all higher digits above it, so one zero test covers the
    // "this and every higher digit is zero" blanking rule.
    assign w_hi    = bcd_q >> {idx_q, 2'b00};
    assign w_nib   = w_hi[3:0];
    assign w_blank = (idx_q != 3'd0) && (w_hi == 20'h00000);

    always_comb begin
        seg = 7'b1111111;
        if (!w_blank) begin
            case (w_nib)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end

    always_comb begin
        an = 5'b11111;
        case (idx_q)
            3'd0:    an = 5'b11110;
            3'd1:    an = 5'b11101;
            3'd2:    an = 5'b11011;
            3'd3:    an = 5'b10111;
            3'd4:    an = 5'b01111;
            default: an = 5'b11111;
        endcase
    end

    assign busy      = busy_q;
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign drop      = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_fib_bcd_display.sv
// ============================================================================
// Module   : tb_fib_bcd_display
// Purpose  : Directed self-checking bench for fib_bcd_display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fib_bcd_display;

    localparam int SCAN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        d_valid;
    logic        busy;
    logic [19:0] bcd;
    logic        bcd_valid;
    logic        drop;
    logic [6:0]  seg;
    logic [4:0]  an;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;   // rising edges since last reset release

    always #5 clk = ~clk;

    fib_bcd_display #(.SCAN_DIV(SCAN)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .d_valid   (d_valid),
        .busy      (busy),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .drop      (drop),
        .seg       (seg),
        .an        (an)
    );

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion: pulse d_valid at E0, expect the result at E16.
    task automatic convert(input logic [15:0] v, input logic [19:0] exp, input string tag);
        d_in    = v;
        d_valid = 1'b1;
        tick;                                   // E0
        check({tag, "_busy_e0"}, {19'd0, busy}, 20'd1);
        d_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick;
            check({tag, "_novalid"}, {19'd0, bcd_valid}, 20'd0);
            check({tag, "_busy"}, {19'd0, busy}, 20'd1);
        end
        tick;                                   // E16
        check({tag, "_valid_e16"}, {19'd0, bcd_valid}, 20'd1);
        check({tag, "_bcd"}, bcd, exp);
        check({tag, "_busy_e16"}, {19'd0, busy}, 20'd0);
        tick;                                   // E17
        check({tag, "_valid_e17"}, {19'd0, bcd_valid}, 20'd0);
        check({tag, "_bcd_hold"}, bcd, exp);
    endtask

    logic [4:0]  an_tab  [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
    logic [6:0]  seg_377 [5] = '{7'b1111000, 7'b1111000, 7'b0110000, 7'b1111111, 7'b1111111};
    int          fib     [25] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377,
                                  610, 987, 1597, 2584, 4181, 6765, 10946, 17711, 28657, 46368};
    logic [19:0] fib_bcd [25] = '{20'h00000, 20'h00001, 20'h00001, 20'h00002, 20'h00003,
                                  20'h00005, 20'h00008, 20'h00013, 20'h00021, 20'h00034,
                                  20'h00055, 20'h00089, 20'h00144, 20'h00233, 20'h00377,
                                  20'h00610, 20'h00987, 20'h01597, 20'h02584, 20'h04181,
                                  20'h06765, 20'h10946, 20'h17711, 20'h28657, 20'h46368};

    initial begin
        rst     = 1'b0;
        d_in    = 16'h0000;
        d_valid = 1'b0;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {19'd0, busy},      20'd0);
        check("rst_bcd",   bcd,                20'h00000);
        check("rst_valid", {19'd0, bcd_valid}, 20'd0);
        check("rst_drop",  {19'd0, drop},      20'd0);
        check("rst_an",    {15'd0, an},        {15'd0, 5'b11110});
        check("rst_seg",   {13'd0, seg},       {13'd0, 7'b1000000});
        rst = 1'b1;
        cyc = 0;

        // ---------------- single value ----------------
        tick;
        convert(16'd377, 20'h00377, "single377");

        // ---------------- display scan ----------------
        for (int k = 0; k < 12; k++) begin
            int ix;
            ix = (cyc / SCAN) % 5;
            check("disp_an",  {15'd0, an},  {15'd0, an_tab[ix]});
            check("disp_seg", {13'd0, seg}, {13'd0, seg_377[ix]});
            tick;
        end

        // ---------------- extremes ----------------
        convert(16'd65535, 20'h65535, "max");
        convert(16'd0,     20'h00000, "zero");
        convert(16'd46368, 20'h46368, "fibmax");
        check("disp_zero_pre", bcd, 20'h46368);

        // ---------------- overrun ----------------
        for (int c = 0; c < 40; c++) begin
            d_in    = 16'(c + 1);
            d_valid = 1'b1;
            tick;
            check("ovr_valid", {19'd0, bcd_valid}, {19'd0, (c == 16 || c == 33)});
            check("ovr_busy",  {19'd0, busy},      {19'd0, !(c == 16 || c == 33)});
            check("ovr_drop",  {19'd0, drop},      {19'd0, (c >= 1)});
            if (c == 16) check("ovr_bcd1",  bcd, 20'h00001);
            if (c == 33) check("ovr_bcd18", bcd, 20'h00018);
        end
        d_valid = 1'b0;
        for (int c = 40; c <= 50; c++) begin
            tick;
            check("ovr_tail_valid", {19'd0, bcd_valid}, {19'd0, (c == 50)});
        end
        check("ovr_bcd35",   bcd,            20'h00035);
        check("ovr_drop_st", {19'd0, drop},  20'd1);

        // ---------------- reset mid-conversion ----------------
        d_in    = 16'd1234;
        d_valid = 1'b1;
        tick;
        d_valid = 1'b0;
        repeat (8) tick;
        check("mid_busy_pre", {19'd0, busy}, 20'd1);
        rst = 1'b0;
        #1;
        check("mid_busy", {19'd0, busy}, 20'd0);
        check("mid_bcd",  bcd,           20'h00000);
        check("mid_drop", {19'd0, drop}, 20'd0);
        check("mid_an",   {15'd0, an},   {15'd0, 5'b11110});
        check("mid_seg",  {13'd0, seg},  {13'd0, 7'b1000000});
        tick;
        rst = 1'b1;
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            check("mid_novalid", {19'd0, bcd_valid}, 20'd0);
            check("mid_bcd_zero", bcd, 20'h00000);
        end

        // ---------------- Fibonacci sequence ----------------
        for (int n = 0; n < 25; n++) begin
            convert(16'(fib[n]), fib_bcd[n], "fibseq");
            repeat (2) tick;
        end
        check("seq_drop", {19'd0, drop}, 20'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fib_bcd_display.md
# fib_bcd_display

Downstream consumer of the Fibonacci sequence generator. It captures each valid 16-bit value, converts it to five BCD digits with an iterative double-dabble (shift-add-3) engine, and drives a time-multiplexed 5-digit 7-segment display with leading-zero blanking. The block sits between the generator's `f_out`/`f_valid` outputs and the board display pins.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each digit stays enabled during display scan. Must be ≥ 1.
- `clk` in 1: single system clock, rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `d_in` in 16: unsigned binary value, connected to the generator's `f_out`.
- `d_valid` in 1: `d_in` qualifier, connected to `f_valid`. Level-sampled on each rising edge.
- `busy` out 1: high while a conversion is in progress.
- `bcd` out 20: last completed conversion. `bcd[3:0]` is ones, `bcd[19:16]` is ten-thousands.
- `bcd_valid` out 1: one-cycle pulse when `bcd` updates.
- `drop` out 1: sticky flag, set when `d_valid` arrives while `busy`. Cleared only by reset.
- `seg` out 7: active-low segments, `{g,f,e,d,c,b,a}`.
- `an` out 5: active-low one-hot digit enable. `an[0]` is the ones digit.

## Operation
- FSM states are IDLE and SHIFT. Reset state is IDLE.
- **IDLE:** when `d_valid`=1, capture `d_in` into the shift register, clear the 20-bit scratch and the step counter, set `busy`=1, and go to SHIFT. When `d_valid`=0, hold.
- **SHIFT:** one double-dabble step per cycle.
  - Each scratch nibble ≥ 5 gets +3.
  - Then `{scratch, shreg}` shifts left by 1.
- The step counter runs 0..15.
- On step 15 the following happen together:
  - `bcd` is loaded with the final scratch.
  - `bcd_valid` pulses to 1.
  - `busy` goes to 0.
  - The FSM returns to IDLE.
- `d_valid`=1 sampled in SHIFT, including the step-15 edge:
  - The value is discarded and `drop` is set to 1.
  - The conversion in flight is unaffected.
- `d_valid` is accepted again on the first edge after the `bcd_valid` pulse.
- All 16-bit inputs 0..65535 convert exactly. No digit exceeds 9. There is no overflow case.
- Display scan:
  - A counter runs 0..`SCAN_DIV`-1.
  - At wrap, the digit index increments 0→1→2→3→4→0.
  - `an` is 0 at bit index and 1 elsewhere.
- `seg` decodes the `bcd` nibble at the current index, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking:
  - Digit i shows blank (1111111) if it and every higher digit are 0, for i ≥ 1.
  - Digit 0 is never blanked, so value 0 shows "0".
- `seg`/`an` are combinational from the registered index and `bcd`. The display shows the previous `bcd` during a conversion.

## Timing
- Reset values:
  - FSM=IDLE, `busy`=0, `bcd`=20'h00000, `bcd_valid`=0, `drop`=0.
  - Scan counter=0, index=0, so `an`=11110 and `seg`=1000000.
- Reset is asynchronous. Asserting it mid-conversion aborts immediately: the partial result is lost, `bcd` returns to 0, and no `bcd_valid` is produced.
- Latency: when `d_valid` is captured at edge E0, `bcd`/`bcd_valid` are set at edge E16 and `bcd_valid` is low again after E17.
- Throughput is one conversion per 17 cycles at most. With continuous `d_valid`, one value is accepted every 17 cycles and the rest are dropped.
- `busy` is high from after E0 through E16, exclusive of the cycle after E16.
- Each digit is enabled for exactly `SCAN_DIV` cycles. Full refresh is 5·`SCAN_DIV` cycles.

## Test plan
- **Reset:** assert `rst`=0 mid-run, at step 8 of a conversion of 1234. Required: immediately `busy`=0, `bcd`=0, `drop`=0, `an`=11110, `seg`=1000000, and no `bcd_valid` pulse afterwards.
- **Single value:** `d_in`=377, `d_valid` pulsed one cycle at E0. Required: `bcd`=20'h00377 and a single `bcd_valid` pulse at E16; `busy` high E0..E16.
- **Extremes:**
  - `d_in`=65535 → `bcd`=20'h65535.
  - `d_in`=0 → `bcd`=20'h00000, with 16-cycle latency each.
  - 46368, the largest 16-bit Fibonacci number, → 20'h46368.
- **Overrun:** `d_valid` held high for 40 cycles with `d_in` incrementing from 1. Required:
  - Conversions start at cycles 0, 17 and 34; results 1 and 18 are reported at cycles 16 and 33.
  - `drop`=1 from cycle 1 and stays 1 until reset.
- **Display** (`SCAN_DIV`=2, `bcd`=20'h00377):
  - `an` cycles 11110, 11101, 11011, 10111, 01111 at 2 cycles each.
  - `seg` cycles 1111000, 1111000, 0110000, 1111111, 1111111.
  - Index 0 returns after 10 cycles.
- **Sequence:** feed the first 25 Fibonacci values 0..46368 at one `d_valid` per 20 cycles. Every `bcd` matches the decimal value and `drop` stays 0.
